fault_sweep_analyzer: RTL and testbench



---
 rtl/fault_sweep_analyzer.sv | 131 +++++++++++++
 tb/tb_fault_sweep_analyzer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_sweep_analyzer.sv
// Exhaustive stuck-at sweep source and response analyzer for NUM_FAULTS faulty CUT copies.
// Optional macro FSA_EARLY_STOP_EN ends the sweep as soon as every fault has been detected.
module fault_sweep_analyzer #(
  parameter int IN_W       = 4,
  parameter int OUT_W      = 2,
  parameter int NUM_FAULTS = 6,
  parameter int SETTLE     = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic [IN_W-1:0]                     pattern,
  output logic                                pattern_valid,
  input  logic [OUT_W-1:0]                    golden_resp,
  input  logic [NUM_FAULTS*OUT_W-1:0]         fault_resp,
  output logic                                busy,
  output logic                                done,
  output logic [NUM_FAULTS-1:0]               detected,
  output logic [NUM_FAULTS*IN_W-1:0]          first_pat,
  output logic [$clog2(NUM_FAULTS+1)-1:0]     coverage
);

  localparam int COV_W = $clog2(NUM_FAULTS + 1);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (SETTLE < 1) begin : g_bad_settle
    $error("SETTLE must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t                       state_reg, state_next;
  logic [IN_W-1:0]              pattern_reg, pattern_next;
  logic [CNT_W-1:0]             cnt_reg, cnt_next;
  logic [NUM_FAULTS-1:0]        detected_reg, detected_next;
  logic [NUM_FAULTS*IN_W-1:0]   first_pat_reg, first_pat_next;
  logic [COV_W-1:0]             coverage_reg, coverage_next;

  logic [NUM_FAULTS-1:0]        mismatch;
  logic [NUM_FAULTS-1:0]        detected_upd;
  logic                         stop_early;

  // Case inequality so that an X/Z on any faulty output bit counts as a detection.
  for (genvar gi = 0; gi < NUM_FAULTS; gi++) begin : g_cmp
    assign mismatch[gi] = (fault_resp[gi*OUT_W +: OUT_W] !== golden_resp);
  end

  assign detected_upd = detected_reg | mismatch;

`ifdef FSA_EARLY_STOP_EN
  assign stop_early = &detected_upd;
`else
  assign stop_early = 1'b0;
`endif

  function automatic logic [COV_W-1:0] popcount(input logic [NUM_FAULTS-1:0] v);
    logic [COV_W-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_FAULTS; i++) s = s + COV_W'(v[i]);
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      pattern_reg   <= '0;
      cnt_reg       <= '0;
      detected_reg  <= '0;
      first_pat_reg <= '0;
      coverage_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      pattern_reg   <= pattern_next;
      cnt_reg       <= cnt_next;
      detected_reg  <= detected_next;
      first_pat_reg <= first_pat_next;
      coverage_reg  <= coverage_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pattern_next   = pattern_reg;
    cnt_next       = cnt_reg;
    detected_next  = detected_reg;
    first_pat_next = first_pat_reg;
    coverage_next  = coverage_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next     = APPLY;
          pattern_next   = '0;
          cnt_next       = '0;
          detected_next  = '0;
          first_pat_next = '0;
          coverage_next  = '0;
        end
      end
      APPLY: begin
        if (cnt_reg == CNT_W'(SETTLE - 1)) state_next = SAMPLE;
        else                               cnt_next   = cnt_reg + 1'b1;
      end
      SAMPLE: begin
        detected_next = detected_upd;
        // Only the first detection of a fault records its pattern.
        for (int k = 0; k < NUM_FAULTS; k++) begin
          if (mismatch[k] && !detected_reg[k]) first_pat_next[k*IN_W +: IN_W] = pattern_reg;
        end
        coverage_next = popcount(detected_upd);
        if ((&pattern_reg) || stop_early) begin
          state_next = DONE;
        end else begin
          state_next   = APPLY;
          pattern_next = pattern_reg + 1'b1;
          cnt_next     = '0;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign pattern       = pattern_reg;
  assign busy          = (state_reg == APPLY) || (state_reg == SAMPLE);
  assign pattern_valid = busy;
  assign done          = (state_reg == DONE);
  assign detected      = detected_reg;
  assign first_pat     = first_pat_reg;
  assign coverage      = coverage_reg;

endmodule

// File: tb/tb_fault_sweep_analyzer.sv
// Directed bench for fault_sweep_analyzer: SETTLE=1 and SETTLE=3 instances checked every cycle
// against a sweep-level model, plus literal expectations for done timing and final results.
module tb_fault_sweep_analyzer;

`ifdef FSA_EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  int   scen = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [3:0]  pattern1, pattern3;
  logic        pv1, pv3, busy1, busy3, done1, done3;
  logic [1:0]  gold1, gold3;
  logic [11:0] fr1, fr3;
  logic [5:0]  det1, det3;
  logic [23:0] fp1, fp3;
  logic [2:0]  cov1, cov3;

  always #5 clk = ~clk;

  fault_sweep_analyzer #(.IN_W(4), .OUT_W(2), .NUM_FAULTS(6), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern1), .pattern_valid(pv1),
    .golden_resp(gold1), .fault_resp(fr1), .busy(busy1), .done(done1),
    .detected(det1), .first_pat(fp1), .coverage(cov1));

  fault_sweep_analyzer #(.IN_W(4), .OUT_W(2), .NUM_FAULTS(6), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern3), .pattern_valid(pv3),
    .golden_resp(gold3), .fault_resp(fr3), .busy(busy3), .done(done3),
    .detected(det3), .first_pat(fp3), .coverage(cov3));

  // Scenario fault model: does copy k disagree with golden at pattern p?
  function automatic bit mis(input int sc, input int k, input int p);
    case (sc)
      0: return (k >= 1) && (p == k + 4);
      1: return (k == 2) || ((k >= 1) && (p == k + 4));
      2: return p >= 3;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] golden_of(input logic [3:0] p);
    return {p[3] ^ p[1], p[2] ^ p[0]};
  endfunction

  always_comb begin
    gold1 = golden_of(pattern1);
    gold3 = golden_of(pattern3);
    fr1 = '0;
    fr3 = '0;
    for (int k = 0; k < 6; k++) begin
      fr1[k*2 +: 2] = gold1 ^ {1'b0, mis(scen, k, int'(pattern1))};
      fr3[k*2 +: 2] = gold3 ^ {1'b0, mis(scen, k, int'(pattern3))};
    end
  end

  // Number of busy cycles in a sweep of settle s.
  function automatic int sweep_len(input int sc, input int s);
    logic [5:0] d;
    d = '0;
    for (int p = 0; p < 16; p++) begin
      for (int k = 0; k < 6; k++) if (mis(sc, k, p)) d[k] = 1'b1;
      if (EARLY && (&d)) return (p + 1) * (s + 1);
    end
    return 16 * (s + 1);
  endfunction

  // Expected outputs in cycle c after the accepted start edge (c=0: nothing started since reset).
  task automatic model_out(input int sl, input int s, input int c, output logic [3:0] pat,
                           output logic bsy, output logic dn, output logic [5:0] det,
                           output logic [23:0] fp, output logic [2:0] cov);
    int len, n;
    pat = '0; bsy = 1'b0; dn = 1'b0; det = '0; fp = '0; cov = '0;
    if (c == 0) return;
    len = sweep_len(sl, s);
    if (c <= len) begin
      bsy = 1'b1;
      n = (c - 1) / (s + 1);
      pat = 4'(n);
    end else begin
      n = len / (s + 1);
      pat = 4'(n - 1);
      dn = (c == len + 1);
    end
    for (int p = 0; p < n; p++)
      for (int k = 0; k < 6; k++)
        if (mis(sl, k, p) && !det[k]) begin
          det[k] = 1'b1;
          fp[k*4 +: 4] = 4'(p);
        end
    for (int k = 0; k < 6; k++) cov = cov + 3'(det[k]);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  int c1 = 0, c3 = 0, sl1 = 0, sl3 = 0;

  function automatic bit model_idle(input int c, input int sl, input int s);
    return (c == 0) || (c > sweep_len(sl, s) + 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c1 <= 0;
      c3 <= 0;
    end else begin
      if (model_idle(c1, sl1, 1) && start) begin
        c1 <= 1; sl1 <= scen;
      end else if (c1 != 0 && c1 <= sweep_len(sl1, 1) + 1) c1 <= c1 + 1;
      if (model_idle(c3, sl3, 3) && start) begin
        c3 <= 1; sl3 <= scen;
      end else if (c3 != 0 && c3 <= sweep_len(sl3, 3) + 1) c3 <= c3 + 1;
    end
  end

  task automatic cmp_dut(input string tag, input int sl, input int s, input int c,
                         input logic [3:0] pat, input logic pv, input logic bsy, input logic dn,
                         input logic [5:0] det, input logic [23:0] fp, input logic [2:0] cov);
    logic [3:0] epat; logic ebsy, edn; logic [5:0] edet; logic [23:0] efp; logic [2:0] ecov;
    model_out(sl, s, c, epat, ebsy, edn, edet, efp, ecov);
    check({tag, ".pattern"}, 32'(pat), 32'(epat));
    check({tag, ".pattern_valid"}, 32'(pv), 32'(ebsy));
    check({tag, ".busy"}, 32'(bsy), 32'(ebsy));
    check({tag, ".done"}, 32'(dn), 32'(edn));
    check({tag, ".detected"}, 32'(det), 32'(edet));
    check({tag, ".first_pat"}, 32'(fp), 32'(efp));
    check({tag, ".coverage"}, 32'(cov), 32'(ecov));
  endtask

  always @(negedge clk) begin
    cmp_dut("s1", sl1, 1, c1, pattern1, pv1, busy1, done1, det1, fp1, cov1);
    cmp_dut("s3", sl3, 3, c3, pattern3, pv3, busy3, done3, det3, fp3, cov3);
  end

  // Start a sweep, optionally pulse start again in cycles a/b, return done cycles of both DUTs.
  task automatic run_sweep(input int sc, input int a, input int b,
                           output int d1, output int d3, output int pulses1);
    d1 = 0; d3 = 0; pulses1 = 0;
    @(posedge clk);
    #1 scen = sc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("cleared_on_start.detected", 32'(det1), 32'd0);
        check("cleared_on_start.coverage", 32'(cov1), 32'd0);
      end
      if (done1) begin
        if (d1 == 0) d1 = i;
        pulses1++;
      end
      if (done3 && d3 == 0) d3 = i;
      start = (i == a) || (i == b);
      if (d1 != 0 && d3 != 0) break;
    end
    start = 1'b0;
  endtask

  int d1, d3, np;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset.pattern", 32'(pattern1), 32'd0);
    check("reset.busy", 32'(busy1), 32'd0);
    check("reset.detected", 32'(det1), 32'd0);
    check("reset.coverage", 32'(cov1), 32'd0);

    // Single-pattern faults on copies 1..5.
    run_sweep(0, 0, 0, d1, d3, np);
    check("sc0.done_cycle", 32'(d1), 32'd33);
    check("sc0.done_cycle_settle3", 32'(d3), 32'd65);
    check("sc0.detected", 32'(det1), 32'b111110);
    check("sc0.first_pat", 32'(fp1), 32'h987650);
    check("sc0.coverage", 32'(cov1), 32'd5);

    // Copy 2 always wrong; extra starts while busy and in DONE are ignored.
    run_sweep(1, 10, 33, d1, d3, np);
    check("sc1.done_cycle", 32'(d1), 32'd33);
    check("sc1.done_pulses", 32'(np), 32'd1);
    check("sc1.detected", 32'(det1), 32'b111110);
    check("sc1.first_pat", 32'(fp1), 32'h987050);
    check("sc1.coverage", 32'(cov1), 32'd5);

    // Every copy first wrong at pattern 3.
    run_sweep(2, 0, 0, d1, d3, np);
    check("sc2.done_cycle", 32'(d1), EARLY ? 32'd9 : 32'd33);
    check("sc2.done_cycle_settle3", 32'(d3), EARLY ? 32'd17 : 32'd65);
    check("sc2.pattern", 32'(pattern1), EARLY ? 32'd3 : 32'd15);
    check("sc2.detected", 32'(det1), 32'b111111);
    check("sc2.first_pat", 32'(fp1), 32'h333333);
    check("sc2.coverage", 32'(cov1), 32'd6);

    // Asynchronous reset in cycle 15 of a sweep.
    @(posedge clk);
    #1 scen = 0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 15; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst.pattern", 32'(pattern1), 32'd0);
    check("async_rst.busy", 32'(busy1), 32'd0);
    check("async_rst.pattern_valid", 32'(pv1), 32'd0);
    check("async_rst.detected", 32'(det1), 32'd0);
    check("async_rst.first_pat", 32'(fp1), 32'd0);
    check("async_rst.coverage", 32'(cov1), 32'd0);
    check("async_rst.busy_settle3", 32'(busy3), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("after_rst.no_done", 32'(done1), 32'd0);
    end
    run_sweep(0, 0, 0, d1, d3, np);
    check("rerun.done_cycle", 32'(d1), 32'd33);
    check("rerun.detected", 32'(det1), 32'b111110);
    check("rerun.first_pat", 32'(fp1), 32'h987650);
    check("rerun.coverage", 32'(cov1), 32'd5);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
